// File: rtl/md_ctrl.sv
// Multiply/divide issue controller: launches MD ops from E, tracks the fixed
// mult/div latency, stalls D-stage MD consumers and flags ops that arrive while busy.
module md_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [2:0] e_mdclass,
  input  logic [2:0] d_mdclass,
  input  logic       flush,
  output logic [2:0] md_op,
  output logic       md_we,
  output logic       stall,
  output logic       busy,
  output logic [1:0] state,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       r_run;

  logic w_is_md;
  logic w_is_long;
  logic w_busy;
  logic w_issue;
  logic w_viol;

  assign w_is_md   = (e_mdclass >= 3'd1) && (e_mdclass <= 3'd6);
  assign w_is_long = (e_mdclass >= 3'd1) && (e_mdclass <= 3'd4);
  assign w_busy    = (r_state != ST_IDLE);

  // md_op/md_we form a one-cycle command strobe with no back-pressure: the MD
  // unit must accept it in the issue cycle. r_run blocks issue in the cycle
  // reset is released so the first command always follows a clean edge.
  assign w_issue = r_run & e_valid & ~flush & ~w_busy & w_is_md;
  assign w_viol  = e_valid & w_is_md & w_busy & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err | w_viol;
    case (r_state)
      ST_IDLE: begin
        if (w_issue && w_is_long) begin
          if (e_mdclass <= 3'd2) begin
            w_state_nxt = ST_MULT;
            w_cnt_nxt   = MULT_CNT;
          end else begin
            w_state_nxt = ST_DIV;
            w_cnt_nxt   = DIV_CNT;
          end
        end
      end
      ST_MULT, ST_DIV: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_run   <= 1'b1;
    end
  end

  assign md_op = w_issue ? e_mdclass : 3'd0;
  assign md_we = w_issue;
  assign busy  = w_busy;
  // Only mult/div consumers wait; mthi/mtlo complete in their issue cycle.
  assign stall = (d_mdclass != 3'd0) & (w_busy | (w_issue & w_is_long));
  assign state = r_state;
  assign err   = r_err;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed vector table, hand-written reset/flush/error
// sequences and a randomized run checked against a cycle-numbered busy-window model.
module tb_md_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       e_valid;
  logic [2:0] e_mdclass;
  logic [2:0] d_mdclass;
  logic       flush;
  logic [2:0] md_op;
  logic       md_we;
  logic       stall;
  logic       busy;
  logic [1:0] state;
  logic       err;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_mdclass(e_mdclass),
    .d_mdclass(d_mdclass), .flush(flush), .md_op(md_op), .md_we(md_we),
    .stall(stall), .busy(busy), .state(state), .err(err)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: an op issued in cycle T keeps the unit busy through cycle T+LAT.
  int cyc       = 0;
  int busy_last = -1;
  int kind      = 0;
  bit m_err     = 1'b0;
  bit m_ready   = 1'b0;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [2:0] d;
    logic       f;
    logic [2:0] op;
    logic       we;
    logic       st;
    logic       bz;
    logic [1:0] sm;
    logic       er;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic v, logic [2:0] c, logic [2:0] d, logic f,
                              logic [2:0] op, logic we, logic st, logic bz,
                              logic [1:0] sm, logic er);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.f = f;
    r.op = op; r.we = we; r.st = st; r.bz = bz; r.sm = sm; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd6);
  endfunction

  function automatic bit m_busy();
    return (reset === 1'b1) && (cyc <= busy_last);
  endfunction

  function automatic bit m_issue();
    return (reset === 1'b1) && m_ready && e_valid && !flush && !m_busy() && is_md(e_mdclass);
  endfunction

  task automatic model_reset();
    busy_last = -1;
    kind      = 0;
    m_err     = 1'b0;
    m_ready   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    bit iss;
    bit bz;
    bit st;
    iss = m_issue();
    bz  = m_busy();
    st  = (reset === 1'b1) && (d_mdclass != 3'd0) &&
          (bz || (iss && e_mdclass >= 3'd1 && e_mdclass <= 3'd4));
    chk($sformatf("%s md_op", tag), int'(md_op), iss ? int'(e_mdclass) : 0);
    chk($sformatf("%s md_we", tag), int'(md_we), int'(iss));
    chk($sformatf("%s stall", tag), int'(stall), int'(st));
    chk($sformatf("%s busy", tag), int'(busy), int'(bz));
    chk($sformatf("%s state", tag), int'(state), bz ? kind : 0);
    chk($sformatf("%s err", tag), int'(err), int'(m_err));
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [2:0] d, input logic f);
    @(negedge clk);
    e_valid   = v;
    e_mdclass = c;
    d_mdclass = d;
    flush     = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1) begin
      if (m_issue()) begin
        if (e_mdclass <= 3'd2) begin
          busy_last = cyc + ML;
          kind      = 1;
        end else if (e_mdclass <= 3'd4) begin
          busy_last = cyc + DL;
          kind      = 2;
        end
      end else if (e_valid && !flush && is_md(e_mdclass) && m_busy()) begin
        m_err = 1'b1;
      end
      m_ready = 1'b1;
    end
    cyc++;
  endtask

  // Assert reset mid-cycle (away from any edge) and check its immediate effect.
  task automatic assert_reset_now(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk($sformatf("%s async state", tag), int'(state), 0);
    chk($sformatf("%s async busy", tag), int'(busy), 0);
    chk($sformatf("%s async err", tag), int'(err), 0);
    check_model(tag);
  endtask

  task automatic release_reset(input string tag);
    tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk($sformatf("%s rel md_we", tag), int'(md_we), 0);
    check_model({tag, " rel"});
    tick();
  endtask

  initial begin
    tbl[0]  = mk(1, 3'd1, 3'd7, 0, 3'd1, 1, 1, 0, 2'd0, 0);
    tbl[1]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[2]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[3]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[4]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[5]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[6]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 0, 0, 2'd0, 0);
    tbl[7]  = mk(1, 3'd4, 3'd7, 1, 3'd0, 0, 0, 0, 2'd0, 0);
    tbl[8]  = mk(0, 3'd0, 3'd7, 0, 3'd0, 0, 0, 0, 2'd0, 0);
    tbl[9]  = mk(1, 3'd6, 3'd1, 0, 3'd6, 1, 0, 0, 2'd0, 0);
    tbl[10] = mk(1, 3'd1, 3'd0, 0, 3'd1, 1, 0, 0, 2'd0, 0);
    tbl[11] = mk(0, 3'd0, 3'd3, 0, 3'd0, 0, 1, 1, 2'd1, 0);
    tbl[12] = mk(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 2'd1, 0);
    tbl[13] = mk(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 2'd1, 0);
    tbl[14] = mk(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 2'd1, 0);
    tbl[15] = mk(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 2'd1, 0);
    tbl[16] = mk(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 2'd0, 0);
    tbl[17] = mk(1, 3'd7, 3'd7, 0, 3'd0, 0, 0, 0, 2'd0, 0);
    tbl[18] = mk(1, 3'd0, 3'd5, 0, 3'd0, 0, 0, 0, 2'd0, 0);

    // Reset held low with an active mult in E: everything must stay quiet.
    reset = 1'b0; e_valid = 1'b1; e_mdclass = 3'd1; d_mdclass = 3'd7; flush = 1'b0;
    model_reset();
    #3;
    chk("rst md_we", int'(md_we), 0);
    chk("rst md_op", int'(md_op), 0);
    chk("rst stall", int'(stall), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst state", int'(state), 0);
    chk("rst err", int'(err), 0);
    tick();
    release_reset("init");

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].f);
      chk($sformatf("vec%0d md_op", i), int'(md_op), int'(tbl[i].op));
      chk($sformatf("vec%0d md_we", i), int'(md_we), int'(tbl[i].we));
      chk($sformatf("vec%0d stall", i), int'(stall), int'(tbl[i].st));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].bz));
      chk($sformatf("vec%0d state", i), int'(state), int'(tbl[i].sm));
      chk($sformatf("vec%0d err", i), int'(err), int'(tbl[i].er));
      tick();
    end

    // div issued at T, flushed div at T+3: the count still runs to completion.
    drive(1, 3'd3, 3'd7, 0);
    chk("divflush issue we", int'(md_we), 1);
    check_model("divflush T");
    tick();
    for (int k = 1; k <= 11; k++) begin
      drive(k == 3, (k == 3) ? 3'd3 : 3'd0, 3'd0, k == 3);
      check_model($sformatf("divflush T+%0d", k));
      if (k == 10) chk("divflush busy T+10", int'(busy), 1);
      if (k == 11) begin
        chk("divflush state T+11", int'(state), 0);
        chk("divflush err", int'(err), 0);
      end
      tick();
    end

    // multu forced into E while busy: ignored, err sticky, async reset clears it.
    drive(1, 3'd2, 3'd7, 0);
    check_model("viol issue");
    tick();
    drive(1, 3'd2, 3'd7, 0);
    chk("viol md_we", int'(md_we), 0);
    check_model("viol busy");
    tick();
    drive(0, 3'd0, 3'd0, 0);
    chk("viol err set", int'(err), 1);
    check_model("viol after");
    tick();
    drive(0, 3'd0, 3'd0, 0);
    chk("viol err held", int'(err), 1);
    assert_reset_now("viol");
    release_reset("viol");

    // multu, reset pulse at T+2, then a div must be busy for exactly DL cycles.
    drive(1, 3'd2, 3'd0, 0);
    check_model("rstmid issue");
    tick();
    drive(0, 3'd0, 3'd0, 0);
    tick();
    drive(0, 3'd0, 3'd0, 0);
    chk("rstmid busy before", int'(busy), 1);
    assert_reset_now("rstmid");
    release_reset("rstmid");
    drive(1, 3'd3, 3'd0, 0);
    chk("rstmid div we", int'(md_we), 1);
    check_model("rstmid div");
    tick();
    for (int k = 1; k <= 11; k++) begin
      drive(0, 3'd0, 3'd0, 0);
      chk($sformatf("rstmid busy T+%0d", k), int'(busy), int'(k <= DL));
      check_model($sformatf("rstmid T+%0d", k));
      tick();
    end

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic       rv;
      logic [2:0] rc;
      logic [2:0] rd;
      logic       rf;
      rv = ($urandom_range(0, 3) != 0);
      rc = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      rf = ($urandom_range(0, 9) == 0);
      drive(rv, rc, rd, rf);
      if ($urandom_range(0, 59) == 0) begin
        assert_reset_now($sformatf("rnd%0d", n));
        release_reset($sformatf("rnd%0d", n));
      end else begin
        check_model($sformatf("rnd%0d", n));
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
